// File: rtl/mux_scan_n_pkg.sv
// Shared definitions for the scanning multiplexer: operating-state encoding
// and the decode of the enable/mode pins into a state.
package mux_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_MAN  = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  function automatic state_t decode_state(input logic nen, input logic mode);
    state_t st;
    if (nen) begin
      st = ST_OFF;
    end else if (mode) begin
      st = ST_SCAN;
    end else begin
      st = ST_MAN;
    end
    return st;
  endfunction

endpackage

// File: rtl/mux_scan_n_scan_counter.sv
// Scan index and dwell counter: holds each channel for DWELL cycles, wraps
// explicitly at CHANNELS-1, pauses when not running, and loads from manual select.
module scan_counter #(
  parameter int CHANNELS = 4,
  parameter int DWELL    = 4,
  localparam int SEL_W   = $clog2(CHANNELS),
  localparam int DW_W    = $clog2(DWELL) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic [SEL_W-1:0] load_idx,
  output logic [SEL_W-1:0] idx,
  output logic [DW_W-1:0]  dwell,
  output logic             wrap_s
);

  logic last_dwell_s;
  logic last_idx_s;

  always_comb begin
    last_dwell_s = (dwell == DW_W'(DWELL - 1));
    last_idx_s   = (idx == SEL_W'(CHANNELS - 1));
    wrap_s       = run & last_dwell_s & last_idx_s;
  end

  // Load wins over run; neither asserted means hold (pause).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      dwell <= '0;
    end else if (load) begin
      idx   <= load_idx;
      dwell <= '0;
    end else if (run) begin
      if (last_dwell_s) begin
        dwell <= '0;
        idx   <= last_idx_s ? '0 : idx + SEL_W'(1);
      end else begin
        dwell <= dwell + DW_W'(1);
      end
    end else begin
      idx   <= idx;
      dwell <= dwell;
    end
  end

endmodule

// File: rtl/mux_scan_n.sv
// Registered N-channel x W-bit multiplexer with manual select and an auto-scan
// mode that steps through channels with a fixed dwell.
module mux_scan_n
  import mux_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 4,
  localparam int SEL_W   = $clog2(CHANNELS),
  localparam int DW_W    = $clog2(DWELL) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]          S,
  input  logic                      mode,
  input  logic                      nEN,
  output logic [WIDTH-1:0]          Y,
  output logic [SEL_W-1:0]          ch,
  output logic                      valid,
  output logic                      wrap
);

  localparam logic [SEL_W:0] CH_LIM = (SEL_W + 1)'(CHANNELS);

  state_t           state_s;
  logic [SEL_W-1:0] idx_s;
  logic [DW_W-1:0]  dwell_s;
  logic             wrap_s;
  logic [SEL_W-1:0] sel_s;
  logic             s_in_range_s;
  logic [SEL_W-1:0] load_idx_s;
  logic [WIDTH-1:0] data_s;

  // The state acted on at an edge is decoded from the pins sampled at that edge.
  always_comb begin
    state_s      = decode_state(nEN, mode);
    s_in_range_s = ({1'b0, S} < CH_LIM);
    load_idx_s   = s_in_range_s ? S : '0;
    sel_s        = (state_s == ST_SCAN) ? idx_s : S;
    data_s       = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel_s == SEL_W'(k)) begin
        data_s = din[k*WIDTH +: WIDTH];
      end
    end
  end

  scan_counter #(
    .CHANNELS (CHANNELS),
    .DWELL    (DWELL)
  ) u_scan_counter (
    .clk      (clk),
    .rst      (rst),
    .run      (state_s == ST_SCAN),
    .load     (state_s == ST_MAN),
    .load_idx (load_idx_s),
    .idx      (idx_s),
    .dwell    (dwell_s),
    .wrap_s   (wrap_s)
  );

  // Output registers; ch is deliberately left untouched while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y     <= '0;
      ch    <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      case (state_s)
        ST_MAN: begin
          Y     <= s_in_range_s ? data_s : '0;
          ch    <= S;
          valid <= s_in_range_s;
          wrap  <= 1'b0;
        end
        ST_SCAN: begin
          Y     <= data_s;
          ch    <= idx_s;
          valid <= 1'b1;
          wrap  <= wrap_s;
        end
        default: begin
          Y     <= '0;
          valid <= 1'b0;
          wrap  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench: default instance (W=2, 4 channels, dwell 4) plus a
// 3-channel, dwell-1 instance for the non-power-of-2 wrap.
module tb_mux_scan_n;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [7:0] din_a = 8'd0;
  logic [1:0] s_a = 2'd0;
  logic       mode_a = 1'b0;
  logic       nen_a = 1'b1;
  logic [1:0] y_a;
  logic [1:0] ch_a;
  logic       valid_a;
  logic       wrap_a;

  logic [5:0] din_b = 6'd0;
  logic [1:0] s_b = 2'd0;
  logic       mode_b = 1'b1;
  logic       nen_b = 1'b1;
  logic [1:0] y_b;
  logic [1:0] ch_b;
  logic       valid_b;
  logic       wrap_b;

  int n_tests = 0;
  int n_fail  = 0;

  mux_scan_n #(.WIDTH(2), .CHANNELS(4), .DWELL(4)) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .S(s_a), .mode(mode_a), .nEN(nen_a),
    .Y(y_a), .ch(ch_a), .valid(valid_a), .wrap(wrap_a)
  );

  mux_scan_n #(.WIDTH(2), .CHANNELS(3), .DWELL(1)) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .S(s_b), .mode(mode_b), .nEN(nen_b),
    .Y(y_b), .ch(ch_b), .valid(valid_b), .wrap(wrap_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [1:0] y, input logic [1:0] c,
                         input logic v, input logic w);
    check_eq({tag, ".Y"}, 32'(y_a), 32'(y));
    check_eq({tag, ".ch"}, 32'(ch_a), 32'(c));
    check_eq({tag, ".valid"}, 32'(valid_a), 32'(v));
    check_eq({tag, ".wrap"}, 32'(wrap_a), 32'(w));
  endtask

  initial begin
    logic [1:0] exp_ch;
    logic [1:0] exp_y;
    logic [1:0] bvals [3];
    bvals[0] = 2'd3;
    bvals[1] = 2'd1;
    bvals[2] = 2'd2;

    // Reset state
    #1;
    check_a("reset", 2'd0, 2'd0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;

    // Manual select, channel C
    din_a  = {2'd3, 2'd2, 2'd1, 2'd0};
    mode_a = 1'b0;
    nen_a  = 1'b0;
    s_a    = 2'd2;
    step();
    check_a("man_s2", 2'd2, 2'd2, 1'b1, 1'b0);

    // Exhaustive manual walk against a one-cycle-delayed reference mux
    exp_ch = 2'd2;
    for (int d = 0; d < 256; d++) begin
      for (int s = 0; s < 4; s++) begin
        for (int e = 0; e < 2; e++) begin
          din_a = 8'(d);
          s_a   = 2'(s);
          nen_a = 1'(e);
          step();
          if (e == 0) begin
            exp_ch = 2'(s);
            exp_y  = din_a[s*2 +: 2];
          end else begin
            exp_y  = 2'd0;
          end
          check_eq("walk.Y", 32'(y_a), 32'(exp_y));
          check_eq("walk.ch", 32'(ch_a), 32'(exp_ch));
          check_eq("walk.valid", 32'(valid_a), 32'(e == 0));
        end
      end
    end

    // Reset asserted mid-run takes effect before the next edge
    din_a  = {2'd3, 2'd2, 2'd1, 2'd0};
    mode_a = 1'b1;
    nen_a  = 1'b0;
    s_a    = 2'd0;
    for (int i = 0; i < 6; i++) step();
    #2;
    rst = 1'b1;
    #1;
    check_a("rst_mid", 2'd0, 2'd0, 1'b0, 1'b0);
    step();
    rst = 1'b0;

    // Scan: each channel held 4 cycles, single wrap pulse at 3->0
    for (int i = 0; i < 16; i++) begin
      step();
      check_a("scan", 2'(i / 4), 2'(i / 4), 1'b1, 1'(i == 15));
    end

    // Pause mid-dwell on channel 1, then resume
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("pre_pause.ch", 32'(ch_a), (i < 4) ? 32'd0 : 32'd1);
    end
    nen_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_a("pause", 2'd0, 2'd1, 1'b0, 1'b0);
    end
    nen_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_a("resume", (i < 2) ? 2'd1 : 2'd2, (i < 2) ? 2'd1 : 2'd2, 1'b1, 1'b0);
    end

    // Input changes during dwell are tracked live
    din_a = {2'd3, 2'd0, 2'd1, 2'd0};
    step();
    check_a("live_din", 2'd0, 2'd2, 1'b1, 1'b0);
    din_a = {2'd3, 2'd2, 2'd1, 2'd0};

    // Manual S=2 then scan: starts at channel 2 for a full dwell
    mode_a = 1'b0;
    s_a    = 2'd2;
    step();
    check_a("switch_man", 2'd2, 2'd2, 1'b1, 1'b0);
    mode_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_a("switch_scan", (i < 4) ? 2'd2 : 2'd3, (i < 4) ? 2'd2 : 2'd3, 1'b1, 1'b0);
    end

    // 3 channels, dwell 1: advances every cycle, wraps 2->0
    nen_a  = 1'b1;
    din_b  = {2'd2, 2'd1, 2'd3};
    mode_b = 1'b1;
    nen_b  = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      check_eq("np2.ch", 32'(ch_b), 32'(i % 3));
      check_eq("np2.Y", 32'(y_b), 32'(bvals[i % 3]));
      check_eq("np2.valid", 32'(valid_b), 32'd1);
      check_eq("np2.wrap", 32'(wrap_b), 32'((i % 3) == 2));
    end
    mode_b = 1'b0;
    s_b    = 2'd3;
    step();
    check_eq("np2_oor.Y", 32'(y_b), 32'd0);
    check_eq("np2_oor.valid", 32'(valid_b), 32'd0);
    check_eq("np2_oor.ch", 32'(ch_b), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
